// File: rtl/apu_alarm_sched.sv
// One-shot alarm scheduler: N_REQ slots share one prescaled tick timebase.
// Expired slots are issued one at a time on a valid/ready port in round-robin order.
module apu_alarm_sched #(
    parameter int N_REQ  = 4,
    parameter int W_CTR  = 20,
    parameter int W_TICK = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W_TICK-1:0]        tick_period,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W_CTR-1:0]   req_delay,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         cancel,
    output logic [N_REQ-1:0]         busy,
    output logic                     evt_valid,
    output logic [$clog2(N_REQ)-1:0] evt_id,
    input  logic                     evt_ready
);

    localparam int W_ID = $clog2(N_REQ);
    localparam logic [W_ID:0] N_REQ_EXT = (W_ID+1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_PENDING = 2'd2,
        S_ISSUED  = 2'd3
    } slot_state_t;

    logic [W_TICK-1:0] r_tick_ctr;
    logic              r_tick;
    slot_state_t       r_state     [N_REQ];
    slot_state_t       w_state_nxt [N_REQ];
    logic [W_CTR-1:0]  r_rem       [N_REQ];
    logic [W_CTR-1:0]  w_rem_nxt   [N_REQ];
    logic              r_evt_valid;
    logic [W_ID-1:0]   r_evt_id;
    logic [W_ID-1:0]   r_rr_ptr;
    logic [N_REQ-1:0]  w_elig;
    logic              w_load;
    logic              w_win_found;
    logic [W_ID-1:0]   w_win_id;
    logic [W_ID:0]     w_idx;

    assign w_load    = !r_evt_valid || evt_ready;
    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;

    // Prescaler: one-cycle tick pulse every tick_period+1 clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_ctr <= '0;
            r_tick     <= 1'b0;
        end else if (r_tick_ctr == '0) begin
            r_tick_ctr <= tick_period;
            r_tick     <= 1'b1;
        end else begin
            r_tick_ctr <= r_tick_ctr - W_TICK'(1);
            r_tick     <= 1'b0;
        end
    end

    // Per-slot status outputs and issue eligibility (a cancelled slot cannot win)
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            busy[i]      = (r_state[i] != S_IDLE);
            req_ready[i] = (r_state[i] == S_IDLE);
            w_elig[i]    = (r_state[i] == S_PENDING) && !cancel[i];
        end
    end

    // Round-robin winner: scan from the highest offset down so the nearest slot at/after rr_ptr wins
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx       = {1'b0, r_rr_ptr} + (W_ID+1)'(k);
            w_idx       = (w_idx >= N_REQ_EXT) ? (w_idx - N_REQ_EXT) : w_idx;
            w_win_found = w_win_found | w_elig[w_idx[W_ID-1:0]];
            w_win_id    = w_elig[w_idx[W_ID-1:0]] ? w_idx[W_ID-1:0] : w_win_id;
        end
    end

    // Slot next-state logic; cancel outranks a same-cycle expiry
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            w_rem_nxt[i]   = r_rem[i];
            case (r_state[i])
                S_IDLE: begin
                    if (req_valid[i]) begin
                        w_rem_nxt[i]   = req_delay[i*W_CTR +: W_CTR];
                        w_state_nxt[i] = (req_delay[i*W_CTR +: W_CTR] == '0) ? S_PENDING : S_ARMED;
                    end else begin
                        w_state_nxt[i] = S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (cancel[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_rem_nxt[i]   = '0;
                    end else if (r_tick) begin
                        w_rem_nxt[i]   = r_rem[i] - W_CTR'(1);
                        w_state_nxt[i] = (r_rem[i] == W_CTR'(1)) ? S_PENDING : S_ARMED;
                    end else begin
                        w_state_nxt[i] = S_ARMED;
                    end
                end
                S_PENDING: begin
                    if (cancel[i]) begin
                        w_state_nxt[i] = S_IDLE;
                    end else if (w_load && w_win_found && (w_win_id == W_ID'(i))) begin
                        w_state_nxt[i] = S_ISSUED;
                    end else begin
                        w_state_nxt[i] = S_PENDING;
                    end
                end
                S_ISSUED: begin
                    if (r_evt_valid && evt_ready) begin
                        w_state_nxt[i] = S_IDLE;
                    end else begin
                        w_state_nxt[i] = S_ISSUED;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_rem_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Slot state and remaining-tick registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_state[i] <= S_IDLE;
                r_rem[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_rem[i]   <= w_rem_nxt[i];
            end
        end
    end

    // Event register and round-robin pointer; held stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load && w_win_found) begin
            r_evt_valid <= 1'b1;
            r_evt_id    <= w_win_id;
            r_rr_ptr    <= (w_win_id == W_ID'(N_REQ - 1)) ? '0 : (w_win_id + W_ID'(1));
        end else if (w_load) begin
            r_evt_valid <= 1'b0;
        end else begin
            r_evt_valid <= r_evt_valid;
        end
    end

endmodule

// File: tb/tb_apu_alarm_sched.sv
// Scoreboard bench for apu_alarm_sched: directed arming scenarios push expected
// event ids; a negedge monitor pops and compares on every event handshake.
module tb_apu_alarm_sched;

    localparam int N  = 4;
    localparam int WC = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    tick_period;
    logic [N-1:0]  req_valid;
    logic [N*WC-1:0] req_delay;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  cancel;
    logic [N-1:0]  busy;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic          evt_ready;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mon_exp;
    int first;
    logic seen;
    logic bad;

    apu_alarm_sched #(.N_REQ(N), .W_CTR(WC), .W_TICK(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick_period(tick_period),
        .req_valid(req_valid), .req_delay(req_delay), .req_ready(req_ready),
        .cancel(cancel), .busy(busy), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [N-1:0] mask, input logic [WC-1:0] d);
        req_valid = mask;
        req_delay = {N{d}};
        wait_edge();
        req_valid = '0;
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            wait_edge();
            done = (exp_q.size() == 0) && !evt_valid;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every accepted event must match the oldest expected id
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_order: got unexpected event id %0d, expected none", evt_id);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(evt_id) != mon_exp) begin
                    errors++;
                    $display("FAIL evt_order: got id %0d, expected id %0d", evt_id, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; tick_period = 8'd3; req_valid = '0; req_delay = '0;
        cancel = '0; evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_evt_id", {30'd0, evt_id}, 32'd0);
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'hF);

        // 1: period 3, slot0 delay 5 accepted on the first edge after release
        req_valid = 4'b0001; req_delay = {N{12'd5}}; rst_n = 1'b1;
        wait_edge();
        req_valid = '0;
        first = 0;
        for (int k = 2; k <= 30; k++) begin
            wait_edge();
            if (evt_valid && first == 0) first = k;
        end
        chk("t1_latency", first, 32'd19);
        chk("t1_evt_id", {30'd0, evt_id}, 32'd0);
        chk("t1_busy", {28'd0, busy}, 32'h1);
        exp_q.push_back(0);
        evt_ready = 1'b1;
        wait_drain("t1_drain");

        // 2: three slots expire together, back-to-back ids 1,2,3
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        arm(4'b1110, 12'd2);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            wait_edge();
            seen = evt_valid;
        end
        chk("t2_first", {31'd0, seen}, 32'd1);
        wait_edge(); chk("t2_b2b_2", {31'd0, evt_valid}, 32'd1);
        wait_edge(); chk("t2_b2b_3", {31'd0, evt_valid}, 32'd1);
        wait_edge(); chk("t2_idle", {31'd0, evt_valid}, 32'd0);
        wait_drain("t2_drain");

        // 3: delay 0 on slot2, stalled consumer, cancel ignored
        evt_ready = 1'b0;
        exp_q.push_back(2);
        arm(4'b0100, 12'd0);
        chk("t3_not_yet", {31'd0, evt_valid}, 32'd0);
        wait_edge();
        chk("t3_valid", {31'd0, evt_valid}, 32'd1);
        chk("t3_id", {30'd0, evt_id}, 32'd2);
        bad = 1'b0;
        cancel = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            wait_edge();
            cancel = '0;
            if (!evt_valid || evt_id != 2'd2 || !busy[2]) bad = 1'b1;
        end
        chk("t3_stable", {31'd0, bad}, 32'd0);
        evt_ready = 1'b1;
        wait_drain("t3_drain");

        // 2b: rr_ptr now 3, so simultaneous expiry issues 3,1,2
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(2);
        arm(4'b1110, 12'd2);
        wait_drain("t2b_drain");

        // 4: cancel an armed slot, then re-arm it
        arm(4'b0010, 12'd4);
        repeat (9) wait_edge();
        chk("t4_armed", {31'd0, busy[1]}, 32'd1);
        cancel = 4'b0010;
        wait_edge();
        cancel = '0;
        chk("t4_busy", {31'd0, busy[1]}, 32'd0);
        chk("t4_ready", {31'd0, req_ready[1]}, 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            wait_edge();
            if (evt_valid) bad = 1'b1;
        end
        chk("t4_no_evt", {31'd0, bad}, 32'd0);
        exp_q.push_back(1);
        arm(4'b0010, 12'd1);
        wait_drain("t4_rearm");

        // 5: tick every clock; delay 1 and the maximum delay
        tick_period = 8'd0;
        repeat (8) wait_edge();
        evt_ready = 1'b0;
        exp_q.push_back(0);
        arm(4'b0001, 12'd1);
        wait_edge(); chk("t5_d1_early", {31'd0, evt_valid}, 32'd0);
        wait_edge(); chk("t5_d1_valid", {31'd0, evt_valid}, 32'd1);
        evt_ready = 1'b1;
        wait_drain("t5_d1_drain");
        evt_ready = 1'b0;
        exp_q.push_back(3);
        arm(4'b1000, 12'hFFF);
        first = 0;
        for (int k = 1; k <= 4200 && first == 0; k++) begin
            wait_edge();
            if (evt_valid) first = k;
        end
        chk("t5_max_latency", first, 32'd4096);
        evt_ready = 1'b1;
        wait_drain("t5_max_drain");

        // 6: asynchronous reset with busy slots and a held event
        evt_ready = 1'b0;
        arm(4'b1000, 12'd0);
        arm(4'b0111, 12'd100);
        wait_edge();
        chk("t6_busy_pre", {28'd0, busy}, 32'hF);
        chk("t6_valid_pre", {31'd0, evt_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("t6_rst_busy", {28'd0, busy}, 32'd0);
        chk("t6_rst_ready", {28'd0, req_ready}, 32'hF);
        chk("t6_rst_id", {30'd0, evt_id}, 32'd0);
        exp_q.delete();
        tick_period = 8'd3;
        wait_edge();
        rst_n = 1'b1;
        req_valid = 4'b0001; req_delay = {N{12'd1}};
        wait_edge();
        req_valid = '0;
        first = 0;
        for (int k = 2; k <= 12 && first == 0; k++) begin
            wait_edge();
            if (evt_valid) first = k;
        end
        chk("t6_first_tick", first, 32'd3);
        exp_q.push_back(0);
        evt_ready = 1'b1;
        wait_drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
